// File: rtl/soc_top.sv
// soc_top: small SoC-style demonstrator built from two peripherals.
//
// Hierarchy: soc_top -> soc_periph (u_periph0, u_periph1) -> soc_counter (u_counter)
//
// Ports (soc_top):
//   clk       in   1  single clock, all state on rising edge
//   rst       in   1  synchronous active-high reset
//   start     in   1  counter enable, sampled each rising edge
//   a         in   8  operand for peripheral 0 (added to count0)
//   b         in   8  operand for peripheral 1 (xor'ed with count1)
//   y0        out  8  registered a + count0
//   y1        out  8  registered b ^ count1
//   mixed     out  8  y0 ^ y1 (or y0 ^ rotl(y1,1), see below)
//   irq_and0  out  1  peripheral 0 wrap-event (start & carry0)
//   irq_or0   out  1  peripheral 0 has-wrapped flag
//   irq_and1  out  1  peripheral 1 wrap-event (start & carry1)
//   irq_or1   out  1  peripheral 1 has-wrapped flag
//
// Optional build macro SOC_TOP_MIXED_ROTATE_EN: when defined, mixed uses
// y1 rotated left by one bit; when undefined, mixed = y0 ^ y1.

// soc_counter: 8-bit step counter with saturating 8-bit wrap counter.
//   clk, rst, en in; count, wrap_count out (8); carry out (carry of count+STEP).
module soc_counter #(
  parameter int unsigned STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] count,
  output logic [7:0] wrap_count,
  output logic       carry
);

  localparam logic [8:0] STEP9 = 9'(STEP);

  logic [8:0] sum;

  // Ninth bit of the sum is the wrap indication for the next enabled edge.
  assign sum   = {1'b0, count} + STEP9;
  assign carry = sum[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 8'h00;
      wrap_count <= 8'h00;
    end else if (en) begin
      count <= sum[7:0];
      // wrap_count saturates so the has-wrapped flag can never fall back to 0
      if (carry && (wrap_count != 8'hFF)) begin
        wrap_count <= wrap_count + 8'h01;
      end
    end
  end

endmodule

// soc_periph: counter plus registered result stage.
//   clk, rst, start, operand (8) in; y (8), irq_and, irq_or out.
//   USE_XOR=0: y <= operand + count; USE_XOR=1: y <= operand ^ count.
module soc_periph #(
  parameter int unsigned STEP    = 1,
  parameter bit          USE_XOR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] operand,
  output logic [7:0] y,
  output logic       irq_and,
  output logic       irq_or
);

  logic [7:0] count;
  logic [7:0] wrap_count;
  logic       carry;
  logic [7:0] result;

  soc_counter #(.STEP(STEP)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (start),
    .count      (count),
    .wrap_count (wrap_count),
    .carry      (carry)
  );

  // Result uses the pre-increment count; it updates every edge, enabled or not.
  always_comb begin
    result = operand + count;
    if (USE_XOR) begin
      result = operand ^ count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= 8'h00;
    end else begin
      y <= result;
    end
  end

  assign irq_and = start & carry;
  assign irq_or  = |wrap_count;

endmodule

module soc_top #(
  parameter int unsigned P0_STEP = 1,
  parameter int unsigned P1_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic [7:0] mixed,
  output logic       irq_and0,
  output logic       irq_or0,
  output logic       irq_and1,
  output logic       irq_or1
);

  soc_periph #(.STEP(P0_STEP), .USE_XOR(1'b0)) u_periph0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (a),
    .y       (y0),
    .irq_and (irq_and0),
    .irq_or  (irq_or0)
  );

  soc_periph #(.STEP(P1_STEP), .USE_XOR(1'b1)) u_periph1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (b),
    .y       (y1),
    .irq_and (irq_and1),
    .irq_or  (irq_or1)
  );

`ifdef SOC_TOP_MIXED_ROTATE_EN
  assign mixed = y0 ^ {y1[6:0], y1[7]};
`else
  assign mixed = y0 ^ y1;
`endif

endmodule

// File: tb/tb_soc_top.sv
module tb_soc_top;

  localparam int P0 = 1;
  localparam int P1 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] y0, y1, mixed;
  logic       irq_and0, irq_or0, irq_and1, irq_or1;

  int checks = 0;
  int failures = 0;

  // reference model: number of enabled edges since last reset, plus result regs
  longint n0 = 0;
  longint n1 = 0;
  logic [7:0] y0_m = 8'h00;
  logic [7:0] y1_m = 8'h00;

  soc_top #(.P0_STEP(P0), .P1_STEP(P1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .y0       (y0),
    .y1       (y1),
    .mixed    (mixed),
    .irq_and0 (irq_and0),
    .irq_or0  (irq_or0),
    .irq_and1 (irq_and1),
    .irq_or1  (irq_or1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_count(int step, longint n);
    return 8'((step * n) % 256);
  endfunction

  function automatic logic [7:0] m_wraps(int step, longint n);
    longint w;
    w = (step * n) / 256;
    return (w > 255) ? 8'hFF : 8'(w);
  endfunction

  function automatic logic m_carry(int step, longint n);
    return (int'(m_count(step, n)) + step) >= 256;
  endfunction

  function automatic logic [7:0] m_mixed(logic [7:0] p, logic [7:0] q);
`ifdef SOC_TOP_MIXED_ROTATE_EN
    return p ^ {q[6:0], q[7]};
`else
    return p ^ q;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: check combinational irq_and before the edge, then
  // advance the model and check all registered state after the edge.
  task automatic do_cycle(input logic r, input logic s, input logic [7:0] va, input logic [7:0] vb);
    rst = r; start = s; a = va; b = vb;
    #2;
    chk("irq_and0", {7'b0, irq_and0}, {7'b0, s & m_carry(P0, n0)});
    chk("irq_and1", {7'b0, irq_and1}, {7'b0, s & m_carry(P1, n1)});
    @(posedge clk);
    if (r) begin
      n0 = 0; n1 = 0; y0_m = 8'h00; y1_m = 8'h00;
    end else begin
      y0_m = va + m_count(P0, n0);
      y1_m = vb ^ m_count(P1, n1);
      if (s) begin n0++; n1++; end
    end
    #1;
    chk("y0", y0, y0_m);
    chk("y1", y1, y1_m);
    chk("mixed", mixed, m_mixed(y0_m, y1_m));
    chk("count0", dut.u_periph0.u_counter.count, m_count(P0, n0));
    chk("count1", dut.u_periph1.u_counter.count, m_count(P1, n1));
    chk("wrap_count0", dut.u_periph0.u_counter.wrap_count, m_wraps(P0, n0));
    chk("wrap_count1", dut.u_periph1.u_counter.wrap_count, m_wraps(P1, n1));
    chk("irq_or0", {7'b0, irq_or0}, {7'b0, m_wraps(P0, n0) != 8'h00});
    chk("irq_or1", {7'b0, irq_or1}, {7'b0, m_wraps(P1, n1) != 8'h00});
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_y0;
    logic [7:0] e_y1;
    logic [7:0] e_mixed;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hits0, hits1, first1, second1;

`ifdef SOC_TOP_MIXED_ROTATE_EN
    vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h12, 8'h34, 8'h12, 8'h34, 8'h7A, 8'h01, 8'h02};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 8'h01, 8'h11, 8'h03, 8'h17, 8'h02, 8'h04};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFB, 8'hF6, 8'h02, 8'h04};
    vecs[5] = '{1'b1, 1'b1, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h12, 8'h34, 8'h12, 8'h34, 8'h26, 8'h01, 8'h02};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 8'h01, 8'h11, 8'h03, 8'h12, 8'h02, 8'h04};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFB, 8'hFA, 8'h02, 8'h04};
    vecs[5] = '{1'b1, 1'b1, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    // table-driven vectors: reset, release, hold, reset overriding start
    for (int i = 0; i < 6; i++) begin
      do_cycle(vecs[i].rst, vecs[i].start, vecs[i].a, vecs[i].b);
      chk("tbl_y0", y0, vecs[i].e_y0);
      chk("tbl_y1", y1, vecs[i].e_y1);
      chk("tbl_mixed", mixed, vecs[i].e_mixed);
      chk("tbl_count0", dut.u_periph0.u_counter.count, vecs[i].e_c0);
      chk("tbl_count1", dut.u_periph1.u_counter.count, vecs[i].e_c1);
    end

    // 256 enabled edges from reset: locate the wrap pulses
    do_cycle(1'b1, 1'b0, 8'h00, 8'h00);
    hits0 = 0; hits1 = 0; first1 = -1; second1 = -1;
    for (int i = 0; i < 256; i++) begin
      rst = 1'b0; start = 1'b1; a = 8'($urandom); b = 8'($urandom);
      #2;
      if (irq_and0) hits0++;
      if (irq_and1) begin
        if (hits1 == 0) first1 = i; else second1 = i;
        hits1++;
      end
      do_cycle(1'b0, 1'b1, a, b);
    end
    chk("irq_and0_pulses", 8'(hits0), 8'd1);
    chk("irq_and1_pulses", 8'(hits1), 8'd2);
    chk("irq_and1_first", 8'(first1), 8'd127);
    chk("irq_and1_second", 8'(second1), 8'd255);
    chk("after256_count0", dut.u_periph0.u_counter.count, 8'h00);
    chk("after256_wrap0", dut.u_periph0.u_counter.wrap_count, 8'h01);
    chk("after256_count1", dut.u_periph1.u_counter.count, 8'h00);
    chk("after256_wrap1", dut.u_periph1.u_counter.wrap_count, 8'h02);
    chk("after256_or", {6'b0, irq_or1, irq_or0}, 8'h03);

    // hold: start=0 for 10 edges
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 8'h03, 8'h1F);
    chk("hold_y0", y0, 8'h03);
    chk("hold_y1", y1, 8'h1F);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      do_cycle(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom), 8'($urandom));

    // saturation run
    do_cycle(1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 70000; i++) do_cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    chk("sat_wrap0", dut.u_periph0.u_counter.wrap_count, 8'hFF);
    chk("sat_wrap1", dut.u_periph1.u_counter.wrap_count, 8'hFF);
    chk("sat_or0", {7'b0, irq_or0}, 8'h01);

    // mid-run reset with start still high
    do_cycle(1'b1, 1'b1, 8'h77, 8'h88);
    chk("mid_y0", y0, 8'h00);
    chk("mid_y1", y1, 8'h00);
    chk("mid_mixed", mixed, 8'h00);
    chk("mid_wrap0", dut.u_periph0.u_counter.wrap_count, 8'h00);
    chk("mid_or", {6'b0, irq_or1, irq_or0}, 8'h00);
    do_cycle(1'b0, 1'b1, 8'h05, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
